// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Definitions shared across the synth design and its loopback/monitor blocks.
//   pwm_demod_state_t  : PWM decoder frame-tracking states
//   PWM_PERIOD_DEFAULT : nominal PWM frame length in clocks
// -----------------------------------------------------------------------------
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE,  // waiting for a rising edge; meters silence
      HIGH,  // measuring the high part of a frame
      LOW    // waiting for the rising edge that closes the frame
   } pwm_demod_state_t;

   localparam int PWM_PERIOD_DEFAULT = 256;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for bringing asynchronous levels into the clk
// domain. Also used for keypad input conditioning.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output, two clocks behind d
// -----------------------------------------------------------------------------
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: non-blocking assignments make meta and q sample together, giving a
   // true two-stage pipeline; blocking ones would collapse it into one flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_demod.sv
// -----------------------------------------------------------------------------
// pwm_demod
// Recovers sample values from a PWM bitstream by measuring the high time of
// each frame. One frame runs from one rising edge to the next.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   en       : decoder enable (level); low forces IDLE and suppresses strobes
//   pwm_i    : PWM stream, asynchronous to clk
//   sample_o : last decoded duty, held between strobes
//   valid_o  : single-cycle strobe for a new sample_o
//   err_o    : frame-length error, only ever high together with valid_o
// Build option:
//   PWM_DEMOD_AVG_EN : when defined, sample_o is the floor average of the
//                      current and previous decoded samples.
// -----------------------------------------------------------------------------
module pwm_demod
   import synth_pkg::*;
#(
   parameter int PERIOD   = PWM_PERIOD_DEFAULT,
   parameter int SAMPLE_W = $clog2(PERIOD)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                pwm_i,
   output logic [SAMPLE_W-1:0] sample_o,
   output logic                valid_o,
   output logic                err_o
);

   // One extra bit lets frame_cnt reach the LOW timeout (1.25 * PERIOD).
   localparam int CNT_W = SAMPLE_W + 1;
   localparam logic [CNT_W-1:0]    ONE          = CNT_W'(1);
   localparam logic [CNT_W-1:0]    FRAME_LAST   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]    FRAME_LEN    = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(PERIOD + PERIOD / 4 - 1);
   localparam logic [SAMPLE_W-1:0] SAMPLE_MAX   = SAMPLE_W'(PERIOD - 1);

   pwm_demod_state_t    state;
   logic [CNT_W-1:0]    frame_cnt;
   logic [CNT_W-1:0]    hi_cnt;
   logic                s;
   logic                s_d;
   logic                rise;
   logic                emit;
   logic                emit_err;
   logic [SAMPLE_W-1:0] emit_val;
   logic [SAMPLE_W-1:0] shaped;

   function automatic logic [SAMPLE_W-1:0] saturate(input logic [CNT_W-1:0] cnt);
      return (cnt > FRAME_LAST) ? SAMPLE_MAX : cnt[SAMPLE_W-1:0];
   endfunction

   sync2 #(.WIDTH(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pwm_i),
      .q   (s)
   );

   // Edge detector keeps running while disabled so a rise right after en
   // returns is seen correctly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_d <= 1'b0;
      else     s_d <= s;
   end

   assign rise = s & ~s_d;

   // Frame-close decode: which cycles produce a strobe, and with what value.
   always_comb begin
      // NOTE: every output gets a default first so no branch can infer a latch.
      emit     = 1'b0;
      emit_val = '0;
      emit_err = 1'b0;
      if (en) begin
         case (state)
            // Silence: a full frame of low without an edge reports zero duty.
            IDLE: if (!s && frame_cnt == FRAME_LAST) emit = 1'b1;
            // Stuck high: a full frame of high reports full scale.
            HIGH: if (s && frame_cnt == FRAME_LAST) begin
               emit     = 1'b1;
               emit_val = SAMPLE_MAX;
            end
            // A rise closes the frame; it also beats a same-cycle timeout.
            LOW: if (rise) begin
               emit     = 1'b1;
               emit_val = saturate(hi_cnt);
               emit_err = (frame_cnt != FRAME_LEN);
            end else if (frame_cnt == TIMEOUT_LAST) begin
               emit     = 1'b1;
               emit_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PWM_DEMOD_AVG_EN
   logic [SAMPLE_W-1:0] prev;
   logic                have_prev;
   logic [SAMPLE_W:0]   sum;

   assign sum    = {1'b0, emit_val} + {1'b0, prev};
   assign shaped = have_prev ? sum[SAMPLE_W:1] : emit_val;

   // History is dropped when disabled so the first strobe afterwards is not
   // blended with a stale sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev      <= '0;
         have_prev <= 1'b0;
      end else if (!en) begin
         prev      <= '0;
         have_prev <= 1'b0;
      end else if (emit) begin
         prev      <= emit_val;
         have_prev <= 1'b1;
      end
   end
`else
   assign shaped = emit_val;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         frame_cnt <= '0;
         hi_cnt    <= '0;
         sample_o  <= '0;
         valid_o   <= 1'b0;
         err_o     <= 1'b0;
      end else if (!en) begin
         // sample_o deliberately keeps its last value.
         state     <= IDLE;
         frame_cnt <= '0;
         hi_cnt    <= '0;
         valid_o   <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         valid_o <= emit;
         err_o   <= emit_err;
         if (emit) sample_o <= shaped;

         case (state)
            IDLE: begin
               // Only a rise leaves IDLE, so a pulse already in progress when
               // en rises is never measured.
               if (rise) begin
                  state     <= HIGH;
                  hi_cnt    <= ONE;
                  frame_cnt <= ONE;
               end else if (!s) begin
                  frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + ONE;
               end
            end
            HIGH: begin
               if (!s) begin
                  state     <= LOW;
                  frame_cnt <= frame_cnt + ONE;
               end else if (frame_cnt == FRAME_LAST) begin
                  frame_cnt <= '0;
                  hi_cnt    <= '0;
               end else begin
                  frame_cnt <= frame_cnt + ONE;
                  hi_cnt    <= hi_cnt + ONE;
               end
            end
            LOW: begin
               if (rise) begin
                  state     <= HIGH;
                  hi_cnt    <= ONE;
                  frame_cnt <= ONE;
               end else if (frame_cnt == TIMEOUT_LAST) begin
                  state     <= IDLE;
                  frame_cnt <= '0;
                  hi_cnt    <= '0;
               end else begin
                  frame_cnt <= frame_cnt + ONE;
               end
            end
            default: begin
               state     <= IDLE;
               frame_cnt <= '0;
               hi_cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_demod.sv
// -----------------------------------------------------------------------------
// tb_pwm_demod
// Self-checking bench for pwm_demod (PERIOD=256, SAMPLE_W=8). Stimulus is
// described as frames (high cycles, low cycles); the expected strobe for a
// frame is its high time, flagged when its length differs from 256, and it
// appears 3 clocks after the raw rising edge that closes the frame. Honours
// PWM_DEMOD_AVG_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_pwm_demod;

   localparam int PERIOD = 256;

   logic       clk;
   logic       rst;
   logic       en;
   logic       pwm_i;
   logic [7:0] sample_o;
   logic       valid_o;
   logic       err_o;

   pwm_demod #(.PERIOD(PERIOD), .SAMPLE_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pwm_i    (pwm_i),
      .sample_o (sample_o),
      .valid_o  (valid_o),
      .err_o    (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] smp;
      logic       err;
   } ev_t;

   typedef struct {
      int         h;
      int         l;
      logic [7:0] smp;
      logic       err;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   bit         mon_on   = 1'b0;
   logic [7:0] hold_ref = '0;
   ev_t        exp_q[int];
   logic [7:0] prev_raw = '0;
   bit         have_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: turns a raw frame measurement into the value sample_o
   // must show, and books it for the given cycle.
   task automatic expect_at(input int at, input logic [7:0] raw, input logic err);
      logic [7:0] out;
      out = raw;
`ifdef PWM_DEMOD_AVG_EN
      if (have_prev) out = 8'((int'(raw) + int'(prev_raw)) / 2);
`endif
      prev_raw  = raw;
      have_prev = 1'b1;
      exp_q[at] = '{smp: out, err: err};
   endtask

   task automatic model_clear();
      prev_raw  = '0;
      have_prev = 1'b0;
   endtask

   // Cycle monitor: every clock either a booked strobe or a quiet cycle with
   // sample_o held at the last strobed value.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (mon_on) begin
         if (exp_q.exists(cyc)) begin
            check("strobe valid", valid_o, 1);
            check("strobe sample", sample_o, exp_q[cyc].smp);
            check("strobe err", err_o, exp_q[cyc].err);
            hold_ref = exp_q[cyc].smp;
            exp_q.delete(cyc);
         end else begin
            check("quiet valid", valid_o, 0);
            check("quiet err", err_o, 0);
            check("held sample", sample_o, hold_ref);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame starting at the current negedge; optionally books the strobe
   // for the previous frame, closed by this frame's rising edge.
   task automatic frame(input int h, input int l, input bit strobe,
                        input logic [7:0] raw, input logic err);
      pwm_i = 1'b1;
      if (strobe) expect_at(cyc + 3, raw, err);
      tick(h);
      pwm_i = 1'b0;
      tick(l);
   endtask

   task automatic close_frame(input logic [7:0] raw, input logic err);
      pwm_i = 1'b1;
      expect_at(cyc + 3, raw, err);
      tick(5);
   endtask

   task automatic restart();
      pwm_i = 1'b0;
      en    = 1'b0;
      model_clear();
      tick(4);
      en = 1'b1;
      tick(2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      int   r;
      int   ph, pl, h, l;

      vecs[0] = '{h: 64,  l: 192, smp: 8'd64,  err: 1'b0};
      vecs[1] = '{h: 128, l: 128, smp: 8'd128, err: 1'b0};
      vecs[2] = '{h: 1,   l: 255, smp: 8'd1,   err: 1'b0};
      vecs[3] = '{h: 255, l: 1,   smp: 8'd255, err: 1'b0};
      vecs[4] = '{h: 50,  l: 150, smp: 8'd50,  err: 1'b1};
      vecs[5] = '{h: 200, l: 100, smp: 8'd200, err: 1'b1};
      vecs[6] = '{h: 10,  l: 309, smp: 8'd10,  err: 1'b1};
      vecs[7] = '{h: 255, l: 64,  smp: 8'd255, err: 1'b1};

      // Power-on reset values.
      rst = 1'b1; en = 1'b1; pwm_i = 1'b0;
      tick(3);
      check("reset sample", sample_o, 0);
      check("reset valid", valid_o, 0);
      check("reset err", err_o, 0);

      // Release in silence: first strobe 256 clocks later.
      rst = 1'b0;
      mon_on = 1'b1;
      expect_at(cyc + 256, 8'd0, 1'b0);
      tick(260);

      // 25 % duty: first strobe on the second rise, then every frame.
      frame(64, 192, 1'b0, 8'd0, 1'b0);
      for (int k = 0; k < 4; k++) frame(64, 192, 1'b1, 8'd64, 1'b0);

      // Reset asserted mid-pulse clears outputs immediately.
      pwm_i = 1'b1;
      expect_at(cyc + 3, 8'd64, 1'b0);
      tick(30);
      #1;
      rst = 1'b1;
      mon_on = 1'b0;
      exp_q.delete();
      hold_ref = '0;
      model_clear();
      #2;
      check("async reset sample", sample_o, 0);
      check("async reset valid", valid_o, 0);
      check("async reset err", err_o, 0);
      @(negedge clk);
      check("held reset sample", sample_o, 0);
      check("held reset valid", valid_o, 0);
      check("held reset err", err_o, 0);
      pwm_i = 1'b0;
      tick(3);
      rst = 1'b0;
      mon_on = 1'b1;
      expect_at(cyc + 256, 8'd0, 1'b0);
      tick(260);

      // Table of steady frame shapes.
      for (int i = 0; i < 8; i++) begin
         restart();
         frame(vecs[i].h, vecs[i].l, 1'b0, 8'd0, 1'b0);
         for (int k = 0; k < 3; k++) frame(vecs[i].h, vecs[i].l, 1'b1, vecs[i].smp, vecs[i].err);
         close_frame(vecs[i].smp, vecs[i].err);
      end

      // Held high (full scale each frame), then held low (LOW timeout, then silence).
      restart();
      r = cyc;
      pwm_i = 1'b1;
      expect_at(r + 258, 8'd255, 1'b0);
      expect_at(r + 514, 8'd255, 1'b0);
      expect_at(r + 770, 8'd255, 1'b0);
      tick(870);
      pwm_i = 1'b0;
      expect_at(r + 1090, 8'd0, 1'b1);
      expect_at(r + 1346, 8'd0, 1'b0);
      expect_at(r + 1602, 8'd0, 1'b0);
      tick(1602 - 870 + 5);

      // en dropped 100 clocks into a 128-high frame: no strobe, sample held;
      // after re-enable the next complete frame is reported.
      restart();
      frame(128, 128, 1'b0, 8'd0, 1'b0);
      frame(128, 128, 1'b1, 8'd128, 1'b0);
      frame(128, 128, 1'b1, 8'd128, 1'b0);
      pwm_i = 1'b1;
      expect_at(cyc + 3, 8'd128, 1'b0);
      tick(100);
      en = 1'b0;
      model_clear();
      tick(28);
      pwm_i = 1'b0;
      tick(128);
      pwm_i = 1'b1;
      tick(128);
      pwm_i = 1'b0;
      tick(22);
      en = 1'b1;
      tick(106);
      frame(128, 128, 1'b0, 8'd0, 1'b0);
      close_frame(8'd128, 1'b0);

      // Duty 64 then 128 (averaged build expects 64 then 96).
      restart();
      frame(64, 192, 1'b0, 8'd0, 1'b0);
      frame(128, 128, 1'b1, 8'd64, 1'b0);
      frame(128, 128, 1'b1, 8'd128, 1'b0);
      close_frame(8'd128, 1'b0);

      // Randomized frames, no timeouts: high 1..255, length up to 319.
      restart();
      ph = $urandom_range(1, 255);
      pl = $urandom_range(1, 319 - ph);
      frame(ph, pl, 1'b0, 8'd0, 1'b0);
      for (int k = 0; k < 30; k++) begin
         h = $urandom_range(1, 255);
         if ($urandom_range(0, 2) == 0) l = PERIOD - h;
         else                           l = $urandom_range(1, 319 - h);
         frame(h, l, 1'b1, 8'((ph > 255) ? 255 : ph), (ph + pl) != PERIOD);
         ph = h;
         pl = l;
      end
      close_frame(8'((ph > 255) ? 255 : ph), (ph + pl) != PERIOD);

      tick(5);
      check("pending strobes", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
